// File: rtl/fetch_cycle.sv
// IF stage: fetch PC, single-outstanding imem req/ready/rvalid handshake,
// IF/ID register (pc_d, pc4_d, instr, instr_valid_d) with stall/flush/redirect.
// Ports: clk, rst (async, active-high); stall_f, flush_d from hazard unit;
//   redirect_en/redirect_pc from execute; imem_req/imem_addr/imem_ready/
//   imem_rvalid/imem_rdata to instruction memory; pc_d, pc4_d, instr,
//   instr_valid_d to decode.
module fetch_cycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        flush_d,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_d,
  output logic [31:0] pc4_d,
  output logic [31:0] instr,
  output logic        instr_valid_d
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [31:0] pc_f;
  logic [31:0] acc_pc;
  logic [31:0] acc_pc4;
  logic [31:0] hold;
  logic [31:0] tgt;
  logic [31:0] load_word;
  logic        accept;
  logic        freeze;
  logic        load;
  logic        capture;
  logic        pending;

  assign acc_pc4 = acc_pc + 32'd4;
  assign tgt     = {redirect_pc[31:2], 2'b00};
  assign accept  = (state == S_REQ) && imem_ready;

  // A flush without a redirect advances the FSM exactly like a stall.
  assign freeze  = stall_f || flush_d;

  // After a redirect, is a response still owed by memory?
  assign pending = accept
                || ((state == S_WAIT) && !imem_rvalid)
                || ((state == S_DROP) && !imem_rvalid);

  assign load    = !redirect_en && !freeze
                && (((state == S_WAIT) && imem_rvalid)
                    || (state == S_HOLD));

  assign capture = !redirect_en && freeze
                && (state == S_WAIT) && imem_rvalid;

  assign load_word = (state == S_HOLD) ? hold : imem_rdata;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_REQ;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (redirect_en) begin
      state_nx = pending ? S_DROP : S_REQ;
    end else begin
      unique case (state)
        S_REQ: begin
          if (imem_ready) state_nx = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) state_nx = freeze ? S_HOLD : S_REQ;
        end
        S_HOLD: begin
          if (!freeze) state_nx = S_REQ;
        end
        S_DROP: begin
          if (imem_rvalid) state_nx = S_REQ;
        end
        default: state_nx = S_REQ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    imem_req  = (state == S_REQ);
    imem_addr = pc_f;
  end

  // Fetch PC, accepted address, hold buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f   <= RESET_PC;
      acc_pc <= RESET_PC;
      hold   <= NOP;
    end else begin
      if (redirect_en) pc_f <= tgt;
      else if (load)   pc_f <= acc_pc4;
      if (accept)  acc_pc <= pc_f;
      if (capture) hold   <= imem_rdata;
    end
  end

  // IF/ID register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_d          <= 32'd0;
      pc4_d         <= 32'd0;
      instr         <= NOP;
      instr_valid_d <= 1'b0;
    end else if (redirect_en || flush_d) begin
      instr         <= NOP;
      instr_valid_d <= 1'b0;
    end else if (load) begin
      pc_d          <= acc_pc;
      pc4_d         <= acc_pc4;
      instr         <= load_word;
      instr_valid_d <= 1'b1;
    end else if (!stall_f) begin
      instr         <= NOP;
      instr_valid_d <= 1'b0;
    end
  end

endmodule
